hazard_stall_ctrl: RTL

- Stall controller for the 5-stage MIPS pipeline.
- Decides each cycle whether the D-stage instruction advances or is held. It holds PC and IF/ID, and clears ID/EX to insert a bubble.
- Tracks destination register and Tnew of the instructions in E and M with its own shadow pipeline.
- Owns the multiply/divide busy counter that gates HI/LO accesses.

---
 rtl/hazard_stall_ctrl_pkg.sv | 37 +++
 rtl/hazard_stall_ctrl_if.sv | 31 +++
 rtl/hazard_stall_ctrl_md.sv | 32 +++
 rtl/hazard_stall_ctrl.sv | 85 ++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall controller.
package hazard_stall_ctrl_pkg;

  // Tuse value for an operand that the instruction does not read.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles after entering E until the result can be forwarded.
  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  // Destination register and remaining Tnew of one shadowed stage.
  typedef struct packed {
    logic [4:0] wdst;
    logic [1:0] tnew;
  } stage_t;

  // Tnew one stage later, held at zero once the result exists.
  function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
    return (tnew == TNEW_LINK) ? TNEW_LINK : tnew - 2'd1;
  endfunction

  // True when source register src is needed before an older E or M
  // instruction can supply it. $0 and unread operands never hazard.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input stage_t     e_stg,
                                      input stage_t     m_stg);
    return (src != '0) && (tuse != TUSE_NONE) &&
           (((src == e_stg.wdst) && (tuse < e_stg.tnew)) ||
            ((src == m_stg.wdst) && (tuse < m_stg.tnew)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// D-stage hazard information in, pipeline hold/bubble controls out.
interface hazard_stall_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [1:0]        d_tuse_rs;
  logic [1:0]        d_tuse_rt;
  logic [4:0]        d_wdst;
  logic [1:0]        d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_clr;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wdst, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  pc_en, ifid_en, idex_clr, md_busy, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wdst, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output pc_en, ifid_en, idex_clr, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl_md.sv
// Multiply/divide busy counter: loads when an MD op sits in E, then
// counts down; busy while the op is in E or the count is nonzero.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic div,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // Load the op latency when it leaves E, otherwise drain to zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = start || (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall controller for the 5-stage pipeline: holds PC and IF/ID and
// bubbles ID/EX on data or multiply/divide hazards.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PERF_W   = 32
) (
  input  logic                 clk,
  input  logic                 clr_n,
  hazard_stall_ctrl_if.slave   bus
);

  stage_t            e_stg;
  stage_t            m_stg;
  logic              e_md;
  logic              e_md_div;
  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic              stall;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cnt;

  // Same-cycle hazard detection against the E and M shadow stages.
  always_comb begin
    stall_rs = src_hazard(bus.d_rs, bus.d_tuse_rs, e_stg, m_stg);
    stall_rt = src_hazard(bus.d_rt, bus.d_tuse_rt, e_stg, m_stg);
    stall_md = bus.d_md_use && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Shadow E/M pipeline; a stall puts a bubble in E but never freezes M.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      e_stg    <= '0;
      e_md     <= 1'b0;
      e_md_div <= 1'b0;
      m_stg    <= '0;
    end else begin
      if (stall) begin
        e_stg    <= '0;
        e_md     <= 1'b0;
        e_md_div <= 1'b0;
      end else begin
        e_stg.wdst <= bus.d_wdst;
        e_stg.tnew <= bus.d_tnew;
        e_md       <= bus.d_md_start;
        e_md_div   <= bus.d_md_div;
      end
      m_stg.wdst <= e_stg.wdst;
      m_stg.tnew <= tnew_age(e_stg.tnew);
    end
  end

  // Saturating count of stall cycles; overlapping causes count once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy (
    .clk   (clk),
    .clr_n (clr_n),
    .start (e_md),
    .div   (e_md_div),
    .busy  (md_busy)
  );

  assign bus.pc_en     = ~stall;
  assign bus.ifid_en   = ~stall;
  assign bus.idex_clr  = stall;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt;

endmodule
